// File: rtl/ext_mem_loader.sv
// Byte-stream program loader: packs bytes into little-endian words and writes them
// to the CPU test top's external memory port, holding the CPU in reset until done.
module ext_mem_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          WORD_COUNT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        Ext_MemWrite,
    output logic [31:0] Ext_WriteData,
    output logic [31:0] Ext_DataAdr,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic [15:0] words_loaded
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [15:0] LAST_WORD = 16'(WORD_COUNT - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [31:0] adr_q, adr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] word_ins;

    // Word register with the incoming byte dropped into the lane selected by idx.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign word_ins[8*gi +: 8] = (idx_q == 2'(gi)) ? rx_data : word_q[8*gi +: 8];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_COLLECT;
                    idx_d   = 2'd0;
                    cnt_d   = 16'd0;
                    adr_d   = BASE_ADDR;
                end
            end
            S_COLLECT: begin
                if (rx_valid) begin
                    word_d = word_ins;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                adr_d   = adr_q + 32'd4;
                cnt_d   = cnt_q + 16'd1;
                state_d = (cnt_q == LAST_WORD) ? S_DONE : S_COLLECT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            word_q  <= 32'd0;
            adr_q   <= BASE_ADDR;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output is either a flop or a pure decode of the state register.
    assign rx_ready      = (state_q == S_COLLECT);
    assign Ext_MemWrite  = (state_q == S_WRITE);
    assign busy          = (state_q == S_COLLECT) || (state_q == S_WRITE);
    assign done          = (state_q == S_DONE);
    assign cpu_reset     = (state_q != S_DONE);
    assign Ext_WriteData = word_q;
    assign Ext_DataAdr   = adr_q;
    assign words_loaded  = cnt_q;

endmodule

// File: tb/tb_ext_mem_loader.sv
// Three loader instances with different base/count share one stimulus stream and are
// each checked every cycle against a transaction-level model of the load.
module tb_ext_mem_loader;

    localparam int NI = 3;
    localparam logic [31:0] BASES [NI] = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0100};
    localparam int          WCS   [NI] = '{2, 2, 1};

    logic        clk = 1'b0;
    logic        reset, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rdy   [NI];
    logic        mw    [NI];
    logic [31:0] wdata [NI];
    logic [31:0] adr   [NI];
    logic        cpur  [NI];
    logic        bsy   [NI];
    logic        dn    [NI];
    logic [15:0] wl    [NI];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        ext_mem_loader #(.BASE_ADDR(BASES[gi]), .WORD_COUNT(WCS[gi])) u_dut (
            .clk(clk), .reset(reset), .start(start),
            .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rdy[gi]),
            .Ext_MemWrite(mw[gi]), .Ext_WriteData(wdata[gi]), .Ext_DataAdr(adr[gi]),
            .cpu_reset(cpur[gi]), .busy(bsy[gi]), .done(dn[gi]), .words_loaded(wl[gi])
        );
    end

    // Load model: "loading" spans a whole load, "wr" marks the one write cycle,
    // nb counts bytes of the word in progress, words counts completed writes.
    typedef struct {
        bit          loading;
        bit          wr;
        bit          fin;
        int          nb;
        logic [31:0] word;
        int          words;
    } mdl_t;

    mdl_t mdl [NI];
    bit   rst_seen;

    function automatic mdl_t mdl_clear();
        mdl_t n;
        n.loading = 0; n.wr = 0; n.fin = 0; n.nb = 0; n.word = 32'd0; n.words = 0;
        return n;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int wc, bit rst, bit st, bit v, logic [7:0] d);
        mdl_t n = m;
        if (rst) return mdl_clear();
        if (m.wr) begin
            n.wr = 0;
            n.words = m.words + 1;
            if (n.words == wc) begin
                n.loading = 0;
                n.fin = 1;
            end
        end else if (m.loading) begin
            if (v) begin
                n.word[8*m.nb +: 8] = d;
                n.nb = m.nb + 1;
                if (n.nb == 4) begin
                    n.nb = 0;
                    n.wr = 1;
                end
            end
        end else if (st) begin
            n.loading = 1; n.fin = 0; n.nb = 0; n.words = 0;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d] observed=%h expected=%h t=%0t", tag, inst, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk("rx_ready",     i, 32'(rdy[i]),  32'(mdl[i].loading && !mdl[i].wr));
            chk("mem_write",    i, 32'(mw[i]),   32'(mdl[i].wr));
            chk("busy",         i, 32'(bsy[i]),  32'(mdl[i].loading));
            chk("done",         i, 32'(dn[i]),   32'(mdl[i].fin));
            chk("cpu_reset",    i, 32'(cpur[i]), 32'(!mdl[i].fin));
            chk("data_adr",     i, adr[i],       BASES[i] + 32'(4 * mdl[i].words));
            chk("words_loaded", i, 32'(wl[i]),   32'(16'(mdl[i].words)));
            if (mdl[i].wr || rst_seen)
                chk("write_data", i, wdata[i], mdl[i].word);
        end
    endtask

    task automatic cycle(input bit rst, input bit st, input bit v, input logic [7:0] d);
        reset = rst; start = st; rx_valid = v; rx_data = d;
        @(posedge clk);
        for (int i = 0; i < NI; i++) mdl[i] = mstep(mdl[i], WCS[i], rst, st, v, d);
        rst_seen = rst;
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 8'($urandom));
    endtask

    task automatic send_gappy(input logic [7:0] d);
        idle($urandom_range(0, 3));
        cycle(0, 0, 1, d);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) mdl[i] = mdl_clear();
        rst_seen = 0;

        // Reset state
        cycle(1, 0, 0, 8'h00);
        cycle(1, 0, 0, 8'h00);
        idle(2);

        // First word back-to-back
        cycle(0, 1, 0, 8'h00);
        cycle(0, 0, 1, 8'h13);
        cycle(0, 0, 1, 8'h05);
        cycle(0, 0, 1, 8'h50);
        cycle(0, 0, 1, 8'h00);
        chk("dir_write_strobe", 0, 32'(mw[0]), 32'd1);
        chk("dir_write_data",   0, wdata[0], 32'h0050_0513);
        chk("dir_write_adr_b",  1, adr[1],   32'hFFFF_FFFC);
        idle(1);
        chk("dir_adr_after", 0, adr[0], 32'h0000_0004);
        chk("dir_words",     0, 32'(wl[0]), 32'd1);
        chk("dir_wc1_done",  2, 32'(dn[2]), 32'd1);

        // Second word with gaps and a start pulse mid-collect
        send_gappy(8'hA1);
        send_gappy(8'hB2);
        cycle(0, 1, 0, 8'h00);
        send_gappy(8'hC3);
        send_gappy(8'hD4);
        chk("dir_write2_data", 0, wdata[0], 32'hD4C3_B2A1);
        idle(1);
        chk("dir_done",     0, 32'(dn[0]),   32'd1);
        chk("dir_cpu_rel",  0, 32'(cpur[0]), 32'd0);
        chk("dir_final_a",  0, adr[0],       32'h0000_0008);
        chk("dir_final_b",  1, adr[1],       32'h0000_0004);
        idle(3);

        // Start in DONE reinitialises
        cycle(0, 1, 0, 8'h00);
        chk("dir_restart_done", 0, 32'(dn[0]),   32'd0);
        chk("dir_restart_cpu",  0, 32'(cpur[0]), 32'd1);

        // Reset after two bytes, with start on the same edge; then a fresh word
        cycle(0, 0, 1, 8'h11);
        cycle(0, 0, 1, 8'h22);
        cycle(1, 1, 0, 8'h00);
        idle(2);
        cycle(0, 1, 0, 8'h00);
        for (int k = 0; k < 4; k++) send_gappy(8'(8'h40 + k));
        chk("dir_fresh_word", 0, wdata[0], 32'h4342_4140);
        idle(1);

        // Reset during a WRITE cycle
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 8'($urandom));
        cycle(1, 0, 0, 8'h00);
        idle(2);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 14) == 0),
                  ($urandom_range(0, 2) != 0), 8'($urandom));
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ext_mem_loader.md
Name: ext_mem_loader

Overview:
Upstream program/data loader for the CPU test top.
- Accepts a byte stream over a valid/ready handshake and packs bytes into little-endian 32-bit words.
- Drives the top's external memory write port (Ext_MemWrite, Ext_WriteData, Ext_DataAdr).
- Holds the CPU in reset (cpu_reset) while loading and releases it once WORD_COUNT words are written.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written.
WORD_COUNT, 64, number of 32-bit words per load; legal range 1..65535.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a load; honoured only in IDLE or DONE
rx_valid  input  1  byte available on rx_data
rx_data  input  8  incoming byte
rx_ready  output  1  loader can accept a byte this cycle
Ext_MemWrite  output  1  one-cycle write strobe to data memory
Ext_WriteData  output  32  assembled word
Ext_DataAdr  output  32  byte address of the current word
cpu_reset  output  1  CPU reset; high except in DONE
busy  output  1  high in COLLECT or WRITE
done  output  1  high in DONE
words_loaded  output  16  words written in the current or last load

Behaviour:
Reset values (after a clk edge with reset=1):
- state=IDLE, rx_ready=0, Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=BASE_ADDR.
- cpu_reset=1, busy=0, done=0, words_loaded=0.
- Internal byte index=0 and shift register=0.

General rules:
- All outputs are registered or decoded directly from the state register; no combinational path from inputs to outputs.
- Byte handshake: a byte transfers on an edge where rx_valid && rx_ready. rx_ready=1 only in COLLECT.

FSM:
- IDLE: cpu_reset=1.
  - start=1 -> COLLECT. Clear byte index, words_loaded=0, Ext_DataAdr=BASE_ADDR.
- COLLECT: rx_ready=1, busy=1.
  - Each accepted byte goes into bits [8*idx+7 : 8*idx] of the word register, then idx increments.
  - The byte accepted at idx=3 completes the word -> WRITE. idx returns to 0.
  - rx_valid gaps of any length are tolerated with no effect.
- WRITE: exactly one cycle.
  - Ext_MemWrite=1, Ext_WriteData=assembled word, Ext_DataAdr=current address; rx_ready=0.
  - On exit: Ext_DataAdr += 4 (modulo 2^32, wraps silently), words_loaded += 1.
  - If words_loaded (before increment) == WORD_COUNT-1 -> DONE; else -> COLLECT.
- DONE: done=1, cpu_reset=0, busy=0, rx_ready=0, Ext_MemWrite=0.
  - Ext_DataAdr and words_loaded hold their final values.
  - start=1 -> COLLECT. Same initialisation as from IDLE; cpu_reset=1 again from the next cycle.

Timing and boundary conditions:
- Latency: if the 4th byte of a word is accepted at edge N, Ext_MemWrite is high in the cycle after edge N (one cycle only). The next byte can be accepted no earlier than edge N+2.
- Last word: cpu_reset falls and done rises in the cycle after the final WRITE cycle.
- Ext_MemWrite is only ever asserted while cpu_reset=1, which satisfies the top's gating of external writes by reset.
- start in COLLECT or WRITE is ignored. rx_valid in IDLE, WRITE or DONE is not accepted (no byte consumed).
- start and reset on the same edge: reset wins.
- Reset mid-load (partial word or during WRITE): the partial word is discarded with no further write; all outputs return to reset values.
- WORD_COUNT=1: a single WRITE, then DONE.

Test Plan:
- Reset -> cpu_reset=1, rx_ready=0, Ext_MemWrite=0, Ext_DataAdr=0x00000000, done=0, words_loaded=0.
- start, then bytes 0x13,0x05,0x50,0x00 back-to-back -> one cycle after the 4th byte: Ext_MemWrite=1, Ext_WriteData=0x00500513, Ext_DataAdr=0x0. Next cycle Ext_DataAdr=0x4, words_loaded=1.
- WORD_COUNT=2, 8 bytes with random rx_valid gaps, start pulsed mid-collect -> exactly two writes at 0x0 and 0x4. The mid-collect start has no effect. After the second write: done=1, cpu_reset=0, words_loaded=2, Ext_DataAdr=0x8.
- Reset after 2 bytes of the first word -> no Ext_MemWrite, state IDLE, Ext_DataAdr=BASE_ADDR. A new start plus 4 bytes writes the word built only from the new bytes.
- BASE_ADDR=32'hFFFF_FFFC, WORD_COUNT=2 -> writes at 0xFFFFFFFC then 0x00000000; final Ext_DataAdr=0x00000004.
- start while in DONE -> cpu_reset=1 and done=0 next cycle, words_loaded=0, Ext_DataAdr=BASE_ADDR, reload proceeds normally.
